i2s_transceiver: RTL and testbench
==================================

I2S_TRANSCEIVER -- requirements
Module: i2s_transceiver

Interface
REQ-001 Parameters, one per line:
- DATA_WIDTH, 24: sample bits per channel.
- SLOT_WIDTH, 32: sclk periods per channel slot; SHALL be >= DATA_WIDTH+1.
- MCLK_HALF, 2: clk cycles per mclk half-period.
- SCLK_HALF, 8: clk cycles per sclk half-period; SHALL be an integer multiple of MCLK_HALF.

REQ-002 Ports, one per line:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  run audio clocks and frames.
- leftJustified  in  1  1 = left-justified framing, 0 = I2S (one-bit delay).
- txData  in  2*DATA_WIDTH  {left,right} playback sample.
- txValid  in  1  txData valid.
- txReady  out  1  holding register empty.
- rxData  out  2*DATA_WIDTH  {left,right} captured sample.
- rxValid  out  1  one-cycle pulse, rxData updated.
- underrun  out  1  sticky, frame started with no TX word.
- clearUnderrun  in  1  clears underrun.
- mclk, sclk, lrck  out  1  I2S clocks.
- dac  out  1  serial playback data.
- adc  in  1  serial capture data.

Function
REQ-003 A single clk-domain divider counter SHALL generate internal sclkRise/sclkFall ticks; mclk SHALL toggle every MCLK_HALF clk cycles and sclk every SCLK_HALF clk cycles, with sclk edges coincident with mclk edges.
REQ-004 A bit counter 0..2*SLOT_WIDTH-1 SHALL advance on each sclkFall; lrck SHALL be 0 for counts 0..SLOT_WIDTH-1 (left) and 1 otherwise, changing only on sclkFall.
REQ-005 Frame start is the sclkFall at which the bit counter wraps to 0; leftJustified SHALL be sampled only at frame start.
REQ-006 dac SHALL change only on sclkFall; channel MSB SHALL appear at slot count 0 (left-justified) or slot count 1 (I2S), MSB first, DATA_WIDTH bits, then 0 for the rest of the slot.
REQ-007 adc SHALL be sampled on sclkRise at the same bit positions as REQ-006; non-data slot bits ignored.
REQ-008 On the sclkRise capturing the last right-channel data bit, rxData SHALL update and rxValid SHALL pulse high for exactly one clk cycle; there is no RX backpressure.
REQ-009 TX holding register (one entry): txReady = holding empty; transfer when txValid && txReady.
REQ-010 At frame start, if holding is full, its content SHALL load the shift register and holding SHALL empty (txReady high next cycle).
REQ-011 At frame start, if holding is empty and txValid is high in that cycle, txData SHALL load the shift register directly; no underrun.
REQ-012 At frame start, if holding is empty and txValid is low, zeros SHALL be transmitted for the frame and underrun SHALL set.
REQ-013 clearUnderrun SHALL clear underrun next cycle; a simultaneous set SHALL win.
REQ-014 enable low SHALL hold mclk, sclk, lrck and dac at 0 and reset the divider and bit counters, preserving holding, rxData and underrun.
REQ-015 On a rising enable edge, the first sclkFall SHALL be a frame start.
REQ-016 enable falling mid-frame SHALL abandon the frame with no rxValid.

Reset
REQ-017 reset SHALL force mclk=0, sclk=0, lrck=0, dac=0, txReady=1, rxValid=0, rxData=0, underrun=0, counters=0 and holding empty, overriding all other inputs including mid-frame.

Verification
Bench parameters: DATA_WIDTH=4, SLOT_WIDTH=8, MCLK_HALF=1, SCLK_HALF=2.
REQ-018 Clocks: enable=1 -> mclk period 2 clk, sclk period 4 clk, lrck period 64 clk, lrck low first 32 clk.
REQ-019 I2S loopback (adc=dac), txData=8'hA5, leftJustified=0 -> dac bits 1,0,1,0 at left slot counts 1-4 and 0,1,0,1 at right slot counts 1-4; rxData=8'hA5 with one rxValid pulse per frame.
REQ-020 Left-justified mode, same data -> MSBs at slot count 0; leftJustified toggled mid-frame takes effect only at the next frame start.
REQ-021 Underrun: no txValid at frame start -> dac all 0 that frame and underrun=1; clearUnderrun pulse -> underrun=0; txValid arriving in the frame-start cycle -> no underrun.
REQ-022 Reset and enable: reset asserted mid-frame -> all REQ-017 values next cycle; enable dropped mid-frame -> clocks at 0 and no rxValid; re-enable -> first sclkFall is frame start.

Source files
------------

// File: rtl/i2s_transceiver.sv
// -----------------------------------------------------------------------------
// i2s_transceiver
//
// Full-duplex I2S / left-justified audio transceiver, master mode. All audio
// clocks (mclk, sclk, lrck) are derived from clk by one divider counter, so
// the whole block lives in the clk domain.
//
// Ports
//   clk, reset       system clock, synchronous active-high reset
//   enable           run audio clocks and frames (low = clocks parked at 0)
//   leftJustified    1 = left-justified framing, 0 = I2S (one-bit delay);
//                    sampled only at frame start
//   txData/txValid   {left,right} playback sample, accepted when txReady
//   txReady          single-entry holding register is empty
//   rxData/rxValid   {left,right} captured sample, rxValid is a 1-cycle pulse
//   underrun         sticky: a frame started with no playback word available
//   clearUnderrun    clears underrun (a simultaneous set wins)
//   mclk/sclk/lrck   audio clocks
//   dac / adc        serial playback / capture data
// -----------------------------------------------------------------------------
module i2s_transceiver #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32,
    parameter int MCLK_HALF  = 2,
    parameter int SCLK_HALF  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      leftJustified,
    input  logic [2*DATA_WIDTH-1:0]   txData,
    input  logic                      txValid,
    output logic                      txReady,
    output logic [2*DATA_WIDTH-1:0]   rxData,
    output logic                      rxValid,
    output logic                      underrun,
    input  logic                      clearUnderrun,
    output logic                      mclk,
    output logic                      sclk,
    output logic                      lrck,
    output logic                      dac,
    input  logic                      adc
);

    localparam int FW         = 2 * DATA_WIDTH;
    localparam int FRAME_BITS = 2 * SLOT_WIDTH;
    localparam int DIV_MAX    = 2 * SCLK_HALF - 1;
    localparam int DCW        = (2 * SCLK_HALF > 1) ? $clog2(2 * SCLK_HALF) : 1;
    localparam int MCW        = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
    localparam int BCW        = $clog2(FRAME_BITS);

    typedef enum logic [1:0] {
        stIdle,   // disabled
        stSync,   // enabled, waiting for the first sclk falling edge
        stRun     // framing active
    } stateType;

    stateType         state;
    stateType         nextState;

    logic [DCW-1:0]   divCnt;
    logic [MCW-1:0]   mclkCnt;
    logic [BCW-1:0]   bitCnt;
    logic [BCW-1:0]   nextBitCnt;

    logic             sclkRise;
    logic             sclkFall;
    logic             mclkTick;
    logic             running;
    logic             frameStart;

    logic             holdFull;
    logic [FW-1:0]    holdData;
    logic [FW-1:0]    txWord;
    logic [FW-1:0]    loadWord;
    logic [FW-1:0]    frameWord;
    logic             ljFrame;
    logic             nextLj;
    logic             underrunSet;

    logic [FW-2:0]    rxShift;
    int               rxPos;
    logic             rxBitValid;
    logic             rxLastBit;

    // Position of a bit count inside its channel's data field: 0 = MSB.
    // Values outside 0..DATA_WIDTH-1 mark padding bits of the slot.
    function automatic int slotPos(input logic [BCW-1:0] cnt, input logic lj);
        int s;
        s = int'(cnt);
        if (s >= SLOT_WIDTH)
            s = s - SLOT_WIDTH;
        return lj ? s : s - 1;
    endfunction

    // Serial bit driven for a given bit count of a {left,right} frame word.
    function automatic logic txBit(input logic [FW-1:0]  word,
                                   input logic [BCW-1:0] cnt,
                                   input logic           lj);
        int pos;
        int n;
        pos = slotPos(cnt, lj);
        if (pos < 0 || pos >= DATA_WIDTH)
            return 1'b0;
        n = (int'(cnt) >= SLOT_WIDTH) ? (DATA_WIDTH - 1 - pos) : (FW - 1 - pos);
        return |(word & (FW'(1) << n));
    endfunction

    // -------------------------------------------------------------------------
    // Clock divider: one counter spans a full sclk period; mclk has its own
    // small counter that wraps in step because SCLK_HALF is a multiple of
    // MCLK_HALF, keeping every sclk edge on an mclk edge.
    // -------------------------------------------------------------------------
    always_comb begin
        sclkRise = enable && (divCnt == DCW'(SCLK_HALF - 1));
        sclkFall = enable && (divCnt == DCW'(DIV_MAX));
        mclkTick = enable && (mclkCnt == MCW'(MCLK_HALF - 1));
    end

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            divCnt  <= '0;
            mclkCnt <= '0;
            mclk    <= 1'b0;
            sclk    <= 1'b0;
        end else begin
            divCnt  <= (divCnt == DCW'(DIV_MAX)) ? '0 : divCnt + DCW'(1);
            mclkCnt <= mclkTick ? '0 : mclkCnt + MCW'(1);
            if (mclkTick)
                mclk <= ~mclk;
            if (sclkRise)
                sclk <= 1'b1;
            else if (sclkFall)
                sclk <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Framing FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset)
            state <= stIdle;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        if (!enable)
            nextState = stIdle;
        else if (sclkFall)
            nextState = stRun;
        else if (state == stIdle)
            nextState = stSync;
    end

    // The bit counter sits at 0 until framing starts, so the first falling
    // edge after enable is treated as a wrap to 0 rather than an advance.
    always_comb begin
        running    = (state == stRun);
        frameStart = sclkFall && (!running || bitCnt == BCW'(FRAME_BITS - 1));
    end

    // -------------------------------------------------------------------------
    // Playback path
    // -------------------------------------------------------------------------
    always_comb begin
        txReady     = ~holdFull;
        underrunSet = frameStart && !holdFull && !txValid;
        if (holdFull)
            loadWord = holdData;
        else if (txValid)
            loadWord = txData;
        else
            loadWord = '0;
        frameWord  = frameStart ? loadWord : txWord;
        nextLj     = frameStart ? leftJustified : ljFrame;
        nextBitCnt = frameStart ? '0 : bitCnt + BCW'(1);
    end

    // A word offered in the frame-start cycle with the holding register empty
    // goes straight to the frame word and never occupies the holding register.
    always_ff @(posedge clk) begin
        if (reset) begin
            holdFull <= 1'b0;
            holdData <= '0;
            txWord   <= '0;
            ljFrame  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (frameStart) begin
                txWord  <= loadWord;
                ljFrame <= leftJustified;
                if (holdFull)
                    holdFull <= 1'b0;
            end else if (txValid && !holdFull) begin
                holdData <= txData;
                holdFull <= 1'b1;
            end

            if (underrunSet)
                underrun <= 1'b1;
            else if (clearUnderrun)
                underrun <= 1'b0;
        end
    end

    // Bit counter, lrck and dac all move together on the sclk falling edge;
    // the values driven are those of the count being entered.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            bitCnt <= '0;
            lrck   <= 1'b0;
            dac    <= 1'b0;
        end else if (sclkFall) begin
            bitCnt <= nextBitCnt;
            lrck   <= (nextBitCnt >= BCW'(SLOT_WIDTH));
            dac    <= txBit(frameWord, nextBitCnt, nextLj);
        end
    end

    // -------------------------------------------------------------------------
    // Capture path
    // -------------------------------------------------------------------------
    always_comb begin
        rxPos      = slotPos(bitCnt, ljFrame);
        rxBitValid = running && (rxPos >= 0) && (rxPos < DATA_WIDTH);
        rxLastBit  = rxBitValid && (bitCnt >= BCW'(SLOT_WIDTH)) &&
                     (rxPos == DATA_WIDTH - 1);
    end

    // Data bits are shifted in MSB first, left then right; a full frame shifts
    // exactly FW bits, so leftovers from an abandoned frame fall off the end.
    always_ff @(posedge clk) begin
        if (reset) begin
            rxShift <= '0;
            rxData  <= '0;
            rxValid <= 1'b0;
        end else begin
            rxValid <= 1'b0;
            if (sclkRise && rxBitValid) begin
                rxShift <= (FW-1)'({rxShift, adc});
                if (rxLastBit) begin
                    rxData  <= {rxShift, adc};
                    rxValid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_transceiver.sv
module tb_i2s_transceiver;

    localparam int DW = 4;
    localparam int SW = 8;
    localparam int MH = 1;
    localparam int SH = 2;
    localparam int FW = 2 * DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          leftJustified;
    logic [FW-1:0] txData;
    logic          txValid;
    logic          txReady;
    logic [FW-1:0] rxData;
    logic          rxValid;
    logic          underrun;
    logic          clearUnderrun;
    logic          mclk;
    logic          sclk;
    logic          lrck;
    logic          dac;
    logic          adc;

    assign adc = dac;   // loopback

    i2s_transceiver #(
        .DATA_WIDTH (DW),
        .SLOT_WIDTH (SW),
        .MCLK_HALF  (MH),
        .SCLK_HALF  (SH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .leftJustified (leftJustified),
        .txData        (txData),
        .txValid       (txValid),
        .txReady       (txReady),
        .rxData        (rxData),
        .rxValid       (rxValid),
        .underrun      (underrun),
        .clearUnderrun (clearUnderrun),
        .mclk          (mclk),
        .sclk          (sclk),
        .lrck          (lrck),
        .dac           (dac),
        .adc           (adc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // k = number of enabled clk edges since enable rose, minus one (-1 = idle).
    int            k = -1;
    bit            mHold = 0;
    logic [FW-1:0] mHoldData = '0;
    logic [FW-1:0] mWord = '0;
    bit            mLj = 0;
    bit            mUnder = 0;
    logic [FW-1:0] mRxData = '0;
    bit            eRxValid = 0;

    // bit index of the frame after edge kk (-1 before the first frame start)
    function automatic int bitCntOf(input int kk);
        int falls;
        if (kk < 0) return -1;
        falls = (kk + 1) / (2 * SH);
        return (falls >= 1) ? (falls - 1) % (2 * SW) : -1;
    endfunction

    function automatic bit isFrameStart(input int kk);
        if (kk < 0) return 0;
        if ((kk + 1) % (2 * SH) != 0) return 0;
        return bitCntOf(kk) == 0;
    endfunction

    function automatic bit expBit(input logic [FW-1:0] w, input int b, input bit lj);
        int s;
        int pos;
        logic [FW-1:0] t;
        s   = b % SW;
        pos = s - (lj ? 0 : 1);
        if (pos < 0 || pos >= DW) return 0;
        t = w >> (((b >= SW) ? 0 : DW) + DW - 1 - pos);
        return t[0];
    endfunction

    task automatic modelEdge();
        bit fs;
        bit under;
        eRxValid = 0;
        if (reset) begin
            k = -1; mHold = 0; mHoldData = '0; mUnder = 0; mRxData = '0; mWord = '0; mLj = 0;
        end else begin
            k     = enable ? k + 1 : -1;
            fs    = isFrameStart(k);
            under = fs && !mHold && !txValid;
            if (fs) begin
                mLj = leftJustified;
                if (mHold) begin
                    mWord = mHoldData;
                    mHold = 0;
                end else if (txValid) begin
                    mWord = txData;
                end else begin
                    mWord = '0;
                end
            end else if (txValid && !mHold) begin
                mHold     = 1;
                mHoldData = txData;
            end
            if (under) mUnder = 1;
            else if (clearUnderrun) mUnder = 0;
            // sclk rising edge: last right-channel data bit completes the word
            if (k >= 0 && (k + 1) % (2 * SH) == SH &&
                bitCntOf(k) == SW + (mLj ? 0 : 1) + DW - 1) begin
                eRxValid = 1;
                mRxData  = mWord;
            end
        end
    endtask

    task automatic compareAll();
        int b;
        b = bitCntOf(k);
        checkVal("mclk",     mclk,     (k < 0) ? 0 : ((k + 1) / MH) % 2);
        checkVal("sclk",     sclk,     (k < 0) ? 0 : ((k + 1) / SH) % 2);
        checkVal("lrck",     lrck,     (b >= SW) ? 1 : 0);
        checkVal("dac",      dac,      (b >= 0) ? expBit(mWord, b, mLj) : 0);
        checkVal("txReady",  txReady,  !mHold);
        checkVal("rxValid",  rxValid,  eRxValid);
        checkVal("rxData",   rxData,   mRxData);
        checkVal("underrun", underrun, mUnder);
    endtask

    task automatic cycle();
        @(posedge clk);
        modelEdge();
        #1;
        compareAll();
    endtask

    initial begin
        reset = 1; enable = 0; leftJustified = 0; txData = '0; txValid = 0; clearUnderrun = 0;
        repeat (3) cycle();
        checkVal("rstTxReady", txReady, 1);
        checkVal("rstRxData", rxData, 0);
        reset = 0;
        cycle();

        // I2S loopback with a fixed word
        txData = 8'hA5; txValid = 1; leftJustified = 0; enable = 1;
        repeat (64 * 3 + 10) cycle();
        checkVal("rxA5", rxData, 8'hA5);

        // left-justified, with mid-frame toggles
        leftJustified = 1;
        repeat (64) cycle();
        leftJustified = 0;
        repeat (20) cycle();
        leftJustified = 1;
        repeat (100) cycle();
        checkVal("rxA5lj", rxData, 8'hA5);

        // underrun, clear, then a word offered only in the frame-start cycle
        txValid = 0;
        repeat (130) cycle();
        checkVal("underrunSet", underrun, 1);
        if (isFrameStart(k + 1)) cycle();
        clearUnderrun = 1;
        cycle();
        clearUnderrun = 0;
        checkVal("underrunClr", underrun, 0);
        for (int g = 0; g < 200 && !isFrameStart(k + 1); g++) cycle();
        txValid = 1; txData = 8'h3C;
        cycle();
        txValid = 0;
        checkVal("noUnderrun", underrun, 0);
        repeat (60) cycle();
        checkVal("rx3C", rxData, 8'h3C);

        // enable dropped mid-frame, then re-enabled
        txValid = 1; txData = 8'h5A;
        repeat (30) cycle();
        enable = 0;
        repeat (5) cycle();
        checkVal("disSclk", sclk, 0);
        enable = 1;
        repeat (80) cycle();

        // reset mid-frame
        repeat (20) cycle();
        reset = 1;
        cycle();
        checkVal("rstUnderrun", underrun, 0);
        checkVal("rstRxValid", rxValid, 0);
        reset = 0;
        repeat (10) cycle();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            txValid = ($urandom_range(0, 9) < 6);
            txData  = FW'($urandom);
            if ($urandom_range(0, 49) == 0) leftJustified = ~leftJustified;
            clearUnderrun = ($urandom_range(0, 39) == 0);
            if (enable && $urandom_range(0, 499) == 0) enable = 0;
            else if (!enable && $urandom_range(0, 7) == 0) enable = 1;
            reset = ($urandom_range(0, 999) == 0);
            cycle();
        end
        reset = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
